// File: rtl/clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// clkgate_ctrl
//   Per-channel clock-gate sequencer. Each channel runs an OFF/WAKE/ON/IDLE
//   FSM. At most one channel may be in WAKE at any time, which limits inrush
//   current. Ties go to the lowest-index OFF channel that is requesting. A
//   channel leaving WAKE hands the slot over on the same edge.
//
// Parameters
//   N        number of gated-clock channels (1..32)
//   WAKE     cycles spent in WAKE before ack (1..255)
//   IW       width of idle_cfg and of each idle counter
//
// Ports
//   clk      single clock, rising edge
//   nreset   asynchronous active-low reset (release synchronised externally)
//   req      per-channel level request for a running clock
//   idle_cfg idle cycles tolerated before gating off (sampled every cycle)
//   te       test enable, forces every en high without touching state
//   en       per-channel gate enable (registered, OR te) for a latch-based ICG
//   ack      per-channel "clock stable and running" (registered)
//   busy     high while any channel is in WAKE
// ---------------------------------------------------------------------------
module clkgate_ctrl #(
   parameter int N    = 4,
   parameter int WAKE = 4,
   parameter int IW   = 8
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] idle_cfg,
   input  logic          te,
   output logic [N-1:0]  en,
   output logic [N-1:0]  ack,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_WAKE = 2'd1,
      S_ON   = 2'd2,
      S_IDLE = 2'd3
   } state_e;

   localparam logic [7:0] WLAST = 8'(WAKE - 1);

   state_e        state_q [N];
   state_e        state_d [N];
   logic [7:0]    wcnt_q  [N];
   logic [7:0]    wcnt_d  [N];
   logic [IW-1:0] icnt_q  [N];
   logic [IW-1:0] icnt_d  [N];
   logic [N-1:0]  en_q;
   logic [N-1:0]  ack_q;

   logic [N-1:0]  in_wake;
   logic [N-1:0]  cand;
   logic [N-1:0]  grant;
   logic          wake_done;

   // WAKE slot arbitration. The slot counts as free when nobody holds it
   // or when the holder exits on this very edge.
   always_comb begin
      in_wake   = '0;
      cand      = '0;
      wake_done = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         in_wake[i] = (state_q[i] == S_WAKE);
         cand[i]    = (state_q[i] == S_OFF) && req[i];
         if (in_wake[i] && (wcnt_q[i] == WLAST))
            wake_done = 1'b1;
      end
      busy = |in_wake;
      // Isolate the lowest set bit, so the lowest-index requester wins.
      grant = '0;
      if (!busy || wake_done)
         grant = cand & (~cand + N'(1));
   end

   // Per-channel next state and counters.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         wcnt_d[i]  = wcnt_q[i];
         icnt_d[i]  = icnt_q[i];
         unique case (state_q[i])
            S_OFF: begin
               if (grant[i]) begin
                  state_d[i] = S_WAKE;
                  wcnt_d[i]  = '0;
               end
            end
            S_WAKE: begin
               if (wcnt_q[i] == WLAST) begin
                  state_d[i] = req[i] ? S_ON : S_IDLE;
                  icnt_d[i]  = '0;
               end else begin
                  wcnt_d[i] = wcnt_q[i] + 8'd1;
               end
            end
            S_ON: begin
               if (!req[i]) begin
                  state_d[i] = S_IDLE;
                  icnt_d[i]  = '0;
               end
            end
            S_IDLE: begin
               if (req[i]) begin
                  state_d[i] = S_ON;
                  icnt_d[i]  = '0;
               end else if (icnt_q[i] >= idle_cfg) begin
                  // ">=" also covers idle_cfg being lowered below the count.
                  state_d[i] = S_OFF;
               end else if (icnt_q[i] != '1) begin
                  icnt_d[i] = icnt_q[i] + IW'(1);
               end
            end
            default: state_d[i] = S_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= S_OFF;
            wcnt_q[i]  <= '0;
            icnt_q[i]  <= '0;
         end
         en_q  <= '0;
         ack_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            wcnt_q[i]  <= wcnt_d[i];
            icnt_q[i]  <= icnt_d[i];
            // Outputs are registered from the next state so they line up
            // with the state register.
            en_q[i]    <= (state_d[i] != S_OFF);
            ack_q[i]   <= (state_d[i] == S_ON) || (state_d[i] == S_IDLE);
         end
      end
   end

   assign en  = en_q | {N{te}};
   assign ack = ack_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
module tb_clkgate_ctrl;
   localparam int N    = 4;
   localparam int WAKE = 4;
   localparam int IW   = 8;

   logic          clk = 1'b0;
   logic          nreset;
   logic          te;
   logic [N-1:0]  req;
   logic [IW-1:0] idle_cfg;
   logic [N-1:0]  en;
   logic [N-1:0]  ack;
   logic          busy;

   int errors = 0;
   int checks = 0;

   clkgate_ctrl #(.N(N), .WAKE(WAKE), .IW(IW)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .req      (req),
      .idle_cfg (idle_cfg),
      .te       (te),
      .en       (en),
      .ack      (ack),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference model: one shared wake slot with a remaining-cycle timer,
   // plus per-channel "powered", "stable", "idling" flags and an idle age.
   bit m_pow  [N];
   bit m_stab [N];
   bit m_idl  [N];
   int m_age  [N];
   int owner;
   int wleft;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_pow[i] = 0; m_stab[i] = 0; m_idl[i] = 0; m_age[i] = 0;
      end
      owner = -1;
      wleft = 0;
   endfunction

   function automatic void model_step();
      int grant;
      bit leaving;
      grant   = -1;
      leaving = (owner >= 0) && (wleft == 1);
      if (owner < 0 || leaving)
         for (int i = 0; i < N; i++)
            if (grant < 0 && !m_pow[i] && req[i]) grant = i;
      for (int i = 0; i < N; i++) begin
         if (i == owner) begin
            if (leaving) begin
               m_stab[i] = 1; m_idl[i] = !req[i]; m_age[i] = 0;
            end
         end else if (m_stab[i]) begin
            if (!m_idl[i]) begin
               if (!req[i]) begin m_idl[i] = 1; m_age[i] = 0; end
            end else if (req[i]) begin
               m_idl[i] = 0;
            end else if (m_age[i] >= int'(idle_cfg)) begin
               m_pow[i] = 0; m_stab[i] = 0; m_idl[i] = 0;
            end else begin
               m_age[i]++;
            end
         end else if (i == grant) begin
            m_pow[i] = 1;
         end
      end
      if (grant >= 0) begin
         owner = grant; wleft = WAKE;
      end else if (leaving) begin
         owner = -1;
      end else if (owner >= 0) begin
         wleft--;
      end
   endfunction

   function automatic logic [N-1:0] exp_en();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_pow[i] | te;
      return r;
   endfunction

   function automatic logic [N-1:0] exp_ack();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_stab[i];
      return r;
   endfunction

   // Advance model and DUT by one edge, then sample 1 time unit later.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nreset = 1'b0; te = 1'b0; req = '0; idle_cfg = 8'd3;
      model_reset();
      #2;
      checks++; if (en !== 4'b0000) begin errors++; $display("FAIL reset_en got=%b exp=%b", en, 4'b0000); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0000); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      te = 1'b1;
      #1;
      checks++; if (en !== 4'b1111) begin errors++; $display("FAIL reset_te_en got=%b exp=%b", en, 4'b1111); end
      te = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b1;
   endtask

   task automatic test_wake_idle();
      logic e_en, e_ack, e_busy;
      idle_cfg = 8'd3;
      req = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         step();
         e_en   = (k >= 1) && (k < 14);
         e_ack  = (k >= 5) && (k < 14);
         e_busy = (k >= 1) && (k < 5);
         checks++; if (en[0] !== e_en) begin errors++; $display("FAIL wake_en0 edge=%0d got=%b exp=%b", k, en[0], e_en); end
         checks++; if (ack[0] !== e_ack) begin errors++; $display("FAIL wake_ack0 edge=%0d got=%b exp=%b", k, ack[0], e_ack); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL wake_busy edge=%0d got=%b exp=%b", k, busy, e_busy); end
         if (k == 9) req = 4'b0000;
      end
   endtask

   task automatic test_arbitration();
      logic [N-1:0] e_en, e_ack;
      logic         e_busy;
      req = 4'b1011;
      for (int k = 1; k <= 16; k++) begin
         step();
         e_en   = {(k >= 9), 1'b0, (k >= 5), (k >= 1)};
         e_ack  = {(k >= 13), 1'b0, (k >= 9), (k >= 5)};
         e_busy = (k >= 1) && (k <= 12);
         checks++; if (en !== e_en) begin errors++; $display("FAIL arb_en edge=%0d got=%b exp=%b", k, en, e_en); end
         checks++; if (ack !== e_ack) begin errors++; $display("FAIL arb_ack edge=%0d got=%b exp=%b", k, ack, e_ack); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL arb_busy edge=%0d got=%b exp=%b", k, busy, e_busy); end
      end
   endtask

   task automatic test_idle_return();
      req = 4'b1111;
      for (int k = 0; k < 6; k++) step();
      checks++; if (ack !== 4'b1111) begin errors++; $display("FAIL idle_pre_ack got=%b exp=%b", ack, 4'b1111); end
      req[2] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 1) req[2] = 1'b1;
         checks++; if (en[2] !== 1'b1 || ack[2] !== 1'b1) begin
            errors++; $display("FAIL idle_hold cyc=%0d got en=%b ack=%b exp en=1 ack=1", k, en[2], ack[2]);
         end
      end
      // Back in ON: a fresh drop must take the full idle_cfg+1 cycles.
      req[2] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++; if (en[2] !== (k < 5)) begin errors++; $display("FAIL idle_timeout edge=%0d got=%b exp=%b", k, en[2], (k < 5)); end
      end
      checks++; if (en !== exp_en() || ack !== exp_ack()) begin
         errors++; $display("FAIL idle_model got en=%b ack=%b exp en=%b ack=%b", en, ack, exp_en(), exp_ack());
      end
   endtask

   task automatic test_reset_mid_wake();
      req = '0;
      for (int k = 0; k < 8; k++) step();
      checks++; if (en !== 4'b0000) begin errors++; $display("FAIL rmw_allof got=%b exp=%b", en, 4'b0000); end
      req = 4'b0010;
      step(); step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmw_inwake got=%b exp=1", busy); end
      nreset = 1'b0;
      #1;
      checks++; if (en !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
         errors++; $display("FAIL rmw_async got en=%b ack=%b busy=%b exp 0000/0000/0", en, ack, busy);
      end
      model_reset();
      #1 nreset = 1'b1;
      step();
      checks++; if (busy !== 1'b1 || en !== 4'b0010 || ack !== 4'b0000) begin
         errors++; $display("FAIL rmw_rewake got en=%b ack=%b busy=%b exp 0010/0000/1", en, ack, busy);
      end
      for (int k = 0; k < 4; k++) step();
      checks++; if (ack !== 4'b0010 || busy !== 1'b0) begin
         errors++; $display("FAIL rmw_ack got ack=%b busy=%b exp 0010/0", ack, busy);
      end
   endtask

   task automatic test_te();
      req = '0;
      nreset = 1'b0; te = 1'b1;
      #1;
      model_reset();
      checks++; if (en !== 4'b1111 || ack !== 4'b0000 || busy !== 1'b0) begin
         errors++; $display("FAIL te_reset got en=%b ack=%b busy=%b exp 1111/0000/0", en, ack, busy);
      end
      #1 nreset = 1'b1;
      step(); step();
      checks++; if (en !== 4'b1111 || ack !== 4'b0000 || busy !== 1'b0) begin
         errors++; $display("FAIL te_off got en=%b ack=%b busy=%b exp 1111/0000/0", en, ack, busy);
      end
      te = 1'b0;
      #1;
      checks++; if (en !== 4'b0000) begin errors++; $display("FAIL te_drop got=%b exp=%b", en, 4'b0000); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(7) == 0) req[i] = ~req[i];
         if ($urandom_range(15) == 0) idle_cfg = 8'($urandom_range(6));
         if ($urandom_range(31) == 0) te = ~te;
         if ($urandom_range(199) == 0) begin
            nreset = 1'b0;
            model_reset();
            #1;
            checks++; if (ack !== 4'b0000 || busy !== 1'b0 || en !== exp_en()) begin
               errors++; $display("FAIL rnd_reset cyc=%0d got en=%b ack=%b busy=%b exp en=%b ack=0000 busy=0", c, en, ack, busy, exp_en());
            end
            #1 nreset = 1'b1;
         end
         step();
         checks++; if (en !== exp_en()) begin errors++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", c, en, exp_en()); end
         checks++; if (ack !== exp_ack()) begin errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, ack, exp_ack()); end
         checks++; if (busy !== (owner >= 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, (owner >= 0)); end
      end
   endtask

   initial begin
      test_reset();
      test_wake_idle();
      test_arbitration();
      test_idle_return();
      test_reset_mid_wake();
      test_te();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clkgate_ctrl.md
CLKGATE_CTRL -- requirements
Module: clkgate_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: number of gated-clock channels, 1..32.
REQ-002 SHALL have parameter WAKE, default 4: cycles a channel spends in WAKE before acknowledge, 1..255.
REQ-003 SHALL have parameter IW, default 8: width of idle_cfg and of each idle counter.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port nreset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N: per-channel request for a running clock; level-sensitive.
REQ-007 SHALL have port idle_cfg  input  IW: idle cycles tolerated before a channel gates off; sampled every cycle.
REQ-008 SHALL have port te  input  1: test enable; forces all enables high.
REQ-009 SHALL have port en  output  N: per-channel gate enable, fed to a low-transparent latch clock gate.
REQ-010 SHALL have port ack  output  N: per-channel "clock stable and running".
REQ-011 SHALL have port busy  output  1: high while any channel is in WAKE.

Function
REQ-012 SHALL run one FSM per channel with states OFF, WAKE, ON, IDLE.
REQ-013 SHALL drive en[i]=1 in WAKE, ON and IDLE; en[i]=0 in OFF; en[i] is a register output OR te.
REQ-014 SHALL drive ack[i]=1 in ON and IDLE, 0 in OFF and WAKE; ack is a register output.
REQ-015 SHALL admit at most one channel into WAKE at a time (inrush limit).
REQ-016 OFF->WAKE SHALL occur when req[i]=1, no channel is in WAKE, and i is the lowest-index OFF channel with req high.
REQ-017 On WAKE entry the wake counter SHALL clear to 0 and increment each cycle; WAKE SHALL last exactly WAKE cycles.
REQ-018 WAKE exit SHALL go to ON if req[i]=1, else to IDLE, on the edge where the counter equals WAKE-1.
REQ-019 A channel leaving WAKE SHALL allow another OFF channel to enter WAKE on that same edge.
REQ-020 ON->IDLE SHALL occur when req[i]=0; the idle counter SHALL clear to 0 on entry.
REQ-021 In IDLE with req[i]=1, the FSM SHALL return to ON on the next edge and clear the idle counter.
REQ-022 In IDLE with req[i]=0, the counter SHALL increment each cycle; when it equals idle_cfg, the next edge SHALL go to OFF.
REQ-023 IDLE therefore SHALL last idle_cfg+1 cycles; idle_cfg=0 yields a one-cycle IDLE.
REQ-024 The idle counter SHALL saturate and not wrap; a live idle_cfg decrease below the count SHALL go to OFF on the next edge.
REQ-025 busy SHALL be combinational OR of (state==WAKE) over all channels.
REQ-026 te SHALL NOT alter FSM state, counters, ack or busy.

Reset
REQ-027 nreset low SHALL immediately, without a clock, force all FSMs to OFF, clear all counters, and drive en=0 (unless te=1), ack=0 and busy=0.
REQ-028 Reset asserted mid-WAKE or mid-IDLE SHALL abort that sequence; after release, channels re-arbitrate from OFF.
REQ-029 Deassertion of nreset SHALL be synchronized externally; the block assumes release is clean relative to clk.

Verification
REQ-030 N=4, WAKE=4, idle_cfg=3; req[0] rises, sampled at edge 1 -> en[0]=1 after edge 1; ack[0]=1 after edge 5; busy high edges 1-5.
REQ-031 req[0] drops, sampled at edge 10 -> IDLE from edge 10; en[0]=0 and ack[0]=0 after edge 14.
REQ-032 req=4'b1011 sampled at edge 1 -> channel 0 wakes at edge 1, channel 1 at edge 5, channel 3 at edge 9; busy stays high edges 1-13.
REQ-033 req[2] drops for 2 cycles in IDLE with idle_cfg=3, then rises again -> en[2] and ack[2] stay 1 throughout; state returns to ON.
REQ-034 nreset pulsed low mid-WAKE of channel 1 -> en, ack and busy all 0 before the next clk edge; channel 1 re-enters WAKE on the first edge after release with req still high.
REQ-035 te=1 during reset and in OFF -> en=4'b1111 while ack=0 and busy=0; te drop restores en to the FSM value.
